// File: rtl/mandel_pkg.sv
// mandel_pkg: types shared by the pixel packing path of the Mandelbrot engine.
//   NIBBLE_W / BYTE_W : pixel (iteration count) width and packed byte width.
//   pack_state_e      : pack FSM states (PACK_LOW = no nibble held, PACK_HIGH = one held).
//   fifo_entry_t      : one FIFO entry, {last, data[7:0]}.
package mandel_pkg;
  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

  typedef enum logic {
    PACK_LOW  = 1'b0,
    PACK_HIGH = 1'b1
  } pack_state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/pixel_packer_if.sv
// pixel_packer_if: pixel input stream and packed byte output stream.
//   in_valid/in_data/in_last/in_ready : engine -> packer pixels.
//   out_valid/out_data/out_last/out_ack : packer -> framebuffer bytes (FWFT, ack pops).
// Modports: slave = packer side, master = engine/framebuffer side.
interface pixel_packer_if;
  import mandel_pkg::*;
  logic                in_valid;
  logic [NIBBLE_W-1:0] in_data;
  logic                in_last;
  logic                in_ready;
  logic                out_valid;
  logic [BYTE_W-1:0]   out_data;
  logic                out_last;
  logic                out_ack;

  modport slave  (input  in_valid, in_data, in_last, out_ack,
                  output in_ready, out_valid, out_data, out_last);
  modport master (output in_valid, in_data, in_last, out_ack,
                  input  in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/pixel_byte_fifo.sv
// pixel_byte_fifo: first-word-fall-through FIFO of fifo_entry_t.
//   clk, reset (async, high), flush (sync clear, highest priority)
//   push/push_entry : write (ignored when full)
//   pop             : drop head (ignored when empty)
//   head            : head entry, combinational from storage
//   full, empty, level : occupancy; full/empty derived from level
module pixel_byte_fifo
  import mandel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fifo_entry_t            push_entry,
  input  logic                   pop,
  output fifo_entry_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  fifo_entry_t     mem_q [DEPTH];
  fifo_entry_t     mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      // Storage is cleared too so the head reads back 0 exactly as after reset.
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/pixel_packer.sv
// pixel_packer: packs 4-bit iteration counts two per byte (older pixel in [3:0])
// and buffers the bytes in a FWFT FIFO for the framebuffer writer.
//   clk, reset (async, high), flush (sync frame-start clear, highest priority)
//   pif (slave)  : pixel in / byte out handshakes
//   level        : bytes held in the FIFO
//   overflow     : sticky, a pixel arrived while full and was dropped
//   frame_done   : one-cycle pulse after the byte carrying the last pixel is popped
// Optional (PIXEL_PACKER_STATS_EN): pixel_count[15:0], drop_count[7:0], saturating.
module pixel_packer
  import mandel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  pixel_packer_if.slave          pif,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   frame_done
`ifdef PIXEL_PACKER_STATS_EN
  ,
  output logic [15:0]            pixel_count,
  output logic [7:0]             drop_count
`endif
);
  pack_state_e         state_q, state_d;
  logic [NIBBLE_W-1:0] nib_q, nib_d;
  logic                overflow_q, overflow_d;
  logic                frame_done_q, frame_done_d;
  logic                push, full, empty, accept, drop, pop;
  fifo_entry_t         push_entry, head;

  pixel_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pif.out_ack),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .level      (level)
  );

  // Ready depends only on FIFO space: a LOW-state pixel that would not push
  // is still refused when full, keeping the handshake FSM-independent.
  assign pif.in_ready  = !full;
  assign pif.out_valid = !empty;
  assign pif.out_data  = head.data;
  assign pif.out_last  = head.last;
  assign accept        = pif.in_valid && !full && !flush;
  assign drop          = pif.in_valid && full && !flush;
  assign pop           = pif.out_ack && !empty && !flush;
  assign overflow      = overflow_q;
  assign frame_done    = frame_done_q;

  always_comb begin
    state_d      = state_q;
    nib_d        = nib_q;
    push         = 1'b0;
    push_entry   = '0;
    overflow_d   = overflow_q | drop;
    frame_done_d = pop && head.last;
    if (flush) begin
      state_d    = PACK_LOW;
      nib_d      = '0;
      overflow_d = 1'b0;
    end else if (accept) begin
      case (state_q)
        PACK_LOW: begin
          if (pif.in_last) begin
            // Lone last pixel: flush it out with a zero high nibble.
            push            = 1'b1;
            push_entry.last = 1'b1;
            push_entry.data = {{NIBBLE_W{1'b0}}, pif.in_data};
          end else begin
            nib_d   = pif.in_data;
            state_d = PACK_HIGH;
          end
        end
        PACK_HIGH: begin
          push            = 1'b1;
          push_entry.last = pif.in_last;
          push_entry.data = {pif.in_data, nib_q};
          state_d         = PACK_LOW;
        end
        default: state_d = PACK_LOW;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PACK_LOW;
      nib_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nib_q        <= nib_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef PIXEL_PACKER_STATS_EN
  logic [15:0] pixel_cnt_q, pixel_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  assign pixel_count = pixel_cnt_q;
  assign drop_count  = drop_cnt_q;

  always_comb begin
    pixel_cnt_d = pixel_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (flush) begin
      pixel_cnt_d = '0;
      drop_cnt_d  = '0;
    end else begin
      if (accept && pixel_cnt_q != 16'hFFFF) pixel_cnt_d = pixel_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 8'hFF)       drop_cnt_d  = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pixel_cnt_q <= pixel_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: directed table, corner-case sequences and random traffic for
// pixel_packer, checked against a byte-queue reference model.
module tb_pixel_packer;
  import mandel_pkg::*;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic [LW-1:0] level;
  logic          overflow, frame_done;
`ifdef PIXEL_PACKER_STATS_EN
  logic [15:0]   pixel_count;
  logic [7:0]    drop_count;
`endif

  pixel_packer_if pif ();

  pixel_packer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .pif        (pif),
    .level      (level),
    .overflow   (overflow),
    .frame_done (frame_done)
`ifdef PIXEL_PACKER_STATS_EN
    ,
    .pixel_count (pixel_count),
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of packed bytes plus an optional pending pixel.
  fifo_entry_t mq[$];
  bit          pend_v, m_ovf, m_fd;
  logic [3:0]  pend_n;
  int          m_pix, m_drop;
  int          n_vec, n_err;

  typedef struct {
    bit         v;
    logic [3:0] d;
    bit         l;
    bit         ack;
    int         lvl;
    logic [7:0] data;
    bit         last;
    bit         fd;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend_v = 0; pend_n = '0; m_ovf = 0; m_fd = 0; m_pix = 0; m_drop = 0;
  endtask

  task automatic check_model();
    chk("out_valid", pif.out_valid, mq.size() != 0);
    chk("in_ready", pif.in_ready, mq.size() < DEPTH);
    chk("level", level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("frame_done", frame_done, m_fd);
    if (mq.size() != 0) begin
      chk("out_data", pif.out_data, mq[0].data);
      chk("out_last", pif.out_last, mq[0].last);
    end
`ifdef PIXEL_PACKER_STATS_EN
    chk("pixel_count", pixel_count, m_pix);
    chk("drop_count", drop_count, m_drop);
`endif
  endtask

  // Apply one cycle of inputs, advance the model, check after the edge.
  task automatic cyc(input bit v, input logic [3:0] d, input bit l, input bit ack, input bit fl);
    bit full;
    pif.in_valid = v; pif.in_data = d; pif.in_last = l; pif.out_ack = ack; flush = fl;
    if (fl) model_reset();
    else begin
      full = (mq.size() == DEPTH);
      m_fd = ack && mq.size() != 0 && mq[0].last;
      if (ack && mq.size() != 0) void'(mq.pop_front());
      if (v && full) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end else if (v) begin
        if (m_pix < 65535) m_pix++;
        if (pend_v) begin
          mq.push_back('{last: l, data: {d, pend_n}});
          pend_v = 0;
        end else if (l) mq.push_back('{last: 1'b1, data: {4'h0, d}});
        else begin
          pend_v = 1; pend_n = d;
        end
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; flush = 1'b0;
    pif.in_valid = 0; pif.in_data = '0; pif.in_last = 0; pif.out_ack = 0;
    model_reset();
    #12;
    chk("rst_out_valid", pif.out_valid, 0);
    chk("rst_in_ready", pif.in_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_last", pif.out_last, 0);
    chk("rst_out_data", pif.out_data, 8'h00);
    reset = 1'b0;

    // Basic packing, odd last pixel, lone last pixel.
    tbl.push_back('{1, 4'h3, 0, 0, 0, 8'h00, 0, 0});
    tbl.push_back('{1, 4'hA, 0, 0, 1, 8'hA3, 0, 0});
    tbl.push_back('{1, 4'h5, 0, 0, 1, 8'hA3, 0, 0});
    tbl.push_back('{1, 4'hC, 0, 0, 2, 8'hA3, 0, 0});
    tbl.push_back('{0, 4'h0, 0, 1, 1, 8'hC5, 0, 0});
    tbl.push_back('{0, 4'h0, 0, 1, 0, 8'h00, 0, 0});
    tbl.push_back('{1, 4'h7, 0, 0, 0, 8'h00, 0, 0});
    tbl.push_back('{1, 4'h9, 1, 0, 1, 8'h97, 1, 0});
    tbl.push_back('{0, 4'h0, 0, 1, 0, 8'h00, 0, 1});
    tbl.push_back('{0, 4'h0, 0, 0, 0, 8'h00, 0, 0});
    tbl.push_back('{1, 4'h4, 1, 0, 1, 8'h04, 1, 0});
    tbl.push_back('{0, 4'h0, 0, 1, 0, 8'h00, 0, 1});
    tbl.push_back('{0, 4'h0, 0, 0, 0, 8'h00, 0, 0});
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ack, 1'b0);
      chk("tbl_level", level, tbl[i].lvl);
      chk("tbl_frame_done", frame_done, tbl[i].fd);
      if (tbl[i].lvl != 0) begin
        chk("tbl_data", pif.out_data, tbl[i].data);
        chk("tbl_last", pif.out_last, tbl[i].last);
      end
    end

    // Fill and overflow: 18 pixels, no acks.
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, i[3:0], 1'b0, 1'b0, 1'b0);
      if (i == 15) begin
        chk("fill_level", level, 8);
        chk("fill_in_ready", pif.in_ready, 0);
        chk("fill_no_ovf", overflow, 0);
      end
      if (i == 16) chk("fill_ovf", overflow, 1);
    end
`ifdef PIXEL_PACKER_STATS_EN
    chk("fill_drop_count", drop_count, 2);
`endif
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("ack_in_ready", pif.in_ready, 1);

    // Flush while a nibble is pending, with a simultaneous pixel.
    cyc(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'hE, 1'b0, 1'b1, 1'b1);
    chk("flush_level", level, 0);
    chk("flush_ovf", overflow, 0);
    cyc(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    chk("flush_low_nibble", pif.out_data, 8'h62);

    // Simultaneous push and pop at level 3.
    for (int i = 1; i <= 5; i++) cyc(1'b1, i[3:0], 1'b0, 1'b0, 1'b0);
    chk("pp_pre_level", level, 3);
    cyc(1'b1, 4'h6, 1'b0, 1'b1, 1'b0);
    chk("pp_level", level, 3);
    chk("pp_head", pif.out_data, 8'h21);

    // Asynchronous reset mid-frame with a pending nibble.
    cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    pif.in_valid = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_level", level, 0);
    chk("arst_out_valid", pif.out_valid, 0);
    check_model();
    #2 reset = 1'b0;
    cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    chk("arst_low_nibble", pif.out_data, 8'h81);

    // Random traffic: slow drain first (fills/drops), then fast drain.
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
          $urandom_range(0, 7) == 0,
          (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 99) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pixel_packer.md
# pixel_packer

Buffers the 4-bit iteration counts produced by the Mandelbrot engine and hands them to the VGA/RP2040 framebuffer writer as packed bytes, two pixels per byte. It sits directly downstream of the engine and upstream of the framebuffer write port. The engine can therefore keep iterating while the framebuffer is busy on its RP2040 transfer, and the write traffic is halved.

## Interface
Parameters:
- DEPTH, 8: byte FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous frame-start clear; same effect as reset.
- in_valid  in  1  pixel strobe from the engine (end of one pixel's iteration).
- in_data  in  4  iteration count (ctr_out).
- in_last  in  1  final pixel of the frame (engine `finished`).
- in_ready  out  1  space available; equals !full.
- out_valid  out  1  head byte present; equals !empty.
- out_data  out  8  head byte; bits [3:0] = older pixel, bits [7:4] = newer pixel.
- out_last  out  1  head byte contains the frame's last pixel.
- out_ack  in  1  framebuffer consumed the head byte (wrote_data pulse).
- level  out  $clog2(DEPTH)+1  number of bytes in the FIFO.
- overflow  out  1  sticky; a pixel was dropped.
- frame_done  out  1  one-cycle pulse when the byte with out_last is popped.

## Operation
- The pack FSM has two states:
  - LOW: no nibble pending. An accepted pixel is written to pack_reg[3:0] and the FSM goes to HIGH.
    - Exception: if in_last is also set, the byte {4'h0, in_data} is pushed with last=1 and the FSM stays in LOW.
  - HIGH: one nibble pending. An accepted pixel forms the byte {in_data, pack_reg[3:0]}, which is pushed with last=in_last, and the FSM goes to LOW.
- Accept means `in_valid && in_ready && !flush`.
- in_ready depends only on the FIFO being full, regardless of pack state. This keeps the handshake independent of the FSM.
- Drops: `in_valid && !in_ready && !flush` discards the pixel and sets overflow. Pack state is unchanged.
- The FIFO is first-word-fall-through. out_data and out_last show the head entry combinationally from storage.
- Pops: `out_ack && out_valid` pops the head. out_ack while empty is ignored.
- Push and pop in the same cycle are legal whenever the FIFO is not full; level is then unchanged.
- frame_done is asserted for one cycle, in the cycle after a pop whose entry had last=1.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. full/empty are derived from level.

## Timing
- Reset values: out_valid=0, in_ready=1, level=0, overflow=0, frame_done=0, out_last=0, out_data=8'h00, FSM=LOW, pointers=0.
- Latency: a pushed byte is visible on out_valid the cycle after the edge that accepted the completing pixel.
- flush takes priority over everything else. On the edge where flush=1:
  - FIFO emptied, FSM=LOW, overflow cleared.
  - A simultaneous input pixel is discarded and does not set overflow.
  - A simultaneous out_ack is ignored.
- Reset asserted mid-frame discards any pending nibble and all buffered bytes immediately (asynchronous).
- Full while in HIGH: the pixel is refused, and the pending nibble is kept until space frees.

## Configuration
- PIXEL_PACKER_STATS_EN, when defined, adds two outputs:
  - pixel_count[15:0]: pixels accepted since reset/flush, saturating at 16'hFFFF.
  - drop_count[7:0]: pixels dropped since reset/flush, saturating at 8'hFF.
  - Both reset to 0 and are cleared by flush.
- Without the macro, these ports and their counters do not exist. All other behaviour is identical.

## Structure
- Shared package mandel_pkg holds:
  - NIBBLE_W=4, BYTE_W=8;
  - the pack FSM enum typedef (PACK_LOW, PACK_HIGH);
  - a packed struct typedef for a FIFO entry {last, data[7:0]}.
- One sub-module, pixel_byte_fifo: the generic FWFT FIFO of entries with push, pop, flush, full, empty and level.
- Packing FSM, overflow, frame_done and the stats counters live in pixel_packer.

## Test plan
- Basic packing: push pixels 3, A, 5, C with out_ack held 0, then ack twice. Expected: bytes 8'hA3 then 8'hC5, last=0, level goes 2→1→0.
- Odd last pixel: push 7, then 9 with in_last=1. Expected: byte 8'h97, last=1; frame_done pulses one cycle after its pop.
- Last pixel alone: push 4 with in_last=1 while FSM is LOW. Expected: byte 8'h04, last=1.
- Fill and overflow (DEPTH=8): push 18 pixels with no acks.
  - 16 pixels accepted; level=8, in_ready=0 from the first FIFO-full cycle onward.
  - The 17th pixel is dropped and overflow=1 (with stats enabled: drop_count=2 after the 18th).
  - After one ack, in_ready=1.
- Simultaneous push and pop at level=3: level stays 3 and data order is preserved.
- Flush/reset mid-frame: flush in HIGH with in_valid=1. Expected: level=0, overflow=0, next pixel lands in the low nibble. Asynchronous reset mid-frame yields the same state without waiting for a clock edge.
